demux_16_8_reg: RTL and testbench

DEMUX_16_8_REG -- requirements
Module: demux_16_8_reg

---
 rtl/demux_16_8_reg.sv | 137 +++++++++++++
 tb/tb_demux_16_8_reg.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_16_8_reg.sv
// -----------------------------------------------------------------------------
// demux_16_8_reg
//
// Purpose:
//   A 1-to-8 write demultiplexer with storage. It is the write-side counterpart
//   of the 8:1 read mux. A write request is captured in a stage-1 holding
//   register. On the next clock edge, stage 2 copies the captured data into the
//   one addressed register Qn.
//   Write latency is two edges from the WE sample to Qn holding the value.
//   WACK pulses for the one cycle that follows each commit edge.
//   BUSY is high while a captured write waits to commit.
//
// Ports:
//   CLK        in   1      rising-edge clock
//   RST        in   1      asynchronous, active-high reset
//   WE         in   1      write request, sampled on every rising edge
//   S0,S1,S2   in   1 ea   destination index {S2,S1,S0}, S0 is the LSB
//   D          in   WIDTH  write data
//   CLR        in   1      synchronous clear of all held registers and
//                          of any pending write
//   Q0..Q7     out  WIDTH  held registers, Qn is selected by index n
//   WACK       out  1      write-commit acknowledge pulse
//   BUSY       out  1      a captured write is pending commit
// -----------------------------------------------------------------------------
module demux_16_8_reg #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic             S0,
  input  logic             S1,
  input  logic             S2,
  input  logic [WIDTH-1:0] D,
  input  logic             CLR,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] Q4,
  output logic [WIDTH-1:0] Q5,
  output logic [WIDTH-1:0] Q6,
  output logic [WIDTH-1:0] Q7,
  output logic             WACK,
  output logic             BUSY
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  logic [2:0]       sel_s;
  logic             valid_r;
  logic [2:0]       idx_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] q_r [8];
  logic             wack_r;
  logic [7:0]       wr_en_s;

  assign sel_s = {S2, S1, S0};

  // Decode the captured index into per-register write enables for stage 2.
  // A non-binary index (X or Z) falls into the default branch, so that commit
  // writes no register. A clear on the same edge also blocks the commit.
  always_comb begin
    wr_en_s = 8'h00;
    if (valid_r && !CLR) begin
      case (idx_r)
        3'd0:    wr_en_s = 8'b0000_0001;
        3'd1:    wr_en_s = 8'b0000_0010;
        3'd2:    wr_en_s = 8'b0000_0100;
        3'd3:    wr_en_s = 8'b0000_1000;
        3'd4:    wr_en_s = 8'b0001_0000;
        3'd5:    wr_en_s = 8'b0010_0000;
        3'd6:    wr_en_s = 8'b0100_0000;
        3'd7:    wr_en_s = 8'b1000_0000;
        default: wr_en_s = 8'h00;
      endcase
    end else begin
      wr_en_s = 8'h00;
    end
  end

  // Stage 1: capture the write request. A clear discards any pending write.
  // It also discards a write sampled on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_r <= 1'b0;
      idx_r   <= 3'b000;
      data_r  <= ZERO_W;
    end else if (CLR) begin
      valid_r <= 1'b0;
      idx_r   <= 3'b000;
      data_r  <= ZERO_W;
    end else begin
      valid_r <= WE;
      if (WE) begin
        idx_r  <= sel_s;
        data_r <= D;
      end
    end
  end

  // Stage 2: commit the captured data into the addressed register.
  // Every other register holds its value. WACK follows the commit edge
  // by one cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) begin
        q_r[i] <= ZERO_W;
      end
      wack_r <= 1'b0;
    end else if (CLR) begin
      for (int i = 0; i < 8; i++) begin
        q_r[i] <= ZERO_W;
      end
      wack_r <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_en_s[i]) begin
          q_r[i] <= data_r;
        end
      end
      wack_r <= |wr_en_s;
    end
  end

  assign Q0   = q_r[0];
  assign Q1   = q_r[1];
  assign Q2   = q_r[2];
  assign Q3   = q_r[3];
  assign Q4   = q_r[4];
  assign Q5   = q_r[5];
  assign Q6   = q_r[6];
  assign Q7   = q_r[7];
  assign WACK = wack_r;
  assign BUSY = valid_r;

endmodule

// File: tb/tb_demux_16_8_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_16_8_reg
//
// Purpose:
//   Directed bench for demux_16_8_reg.
//   A table of single-cycle vectors covers the write, collision and clear
//   behaviour. Each vector holds the inputs and the hand-computed expected
//   outputs.
//   Hand-written sequences cover the async reset, the single write, the
//   eight-write burst and the abort scenarios.
// -----------------------------------------------------------------------------
module tb_demux_16_8_reg;

  logic        CLK;
  logic        RST;
  logic        WE;
  logic        S0, S1, S2;
  logic [15:0] D;
  logic        CLR;
  logic [15:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
  logic        WACK;
  logic        BUSY;

  logic [15:0] q_arr [8];

  int errors = 0;
  int checks = 0;

  demux_16_8_reg #(.WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .WE(WE), .S0(S0), .S1(S1), .S2(S2), .D(D),
    .CLR(CLR), .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5),
    .Q6(Q6), .Q7(Q7), .WACK(WACK), .BUSY(BUSY)
  );

  assign q_arr[0] = Q0;
  assign q_arr[1] = Q1;
  assign q_arr[2] = Q2;
  assign q_arr[3] = Q3;
  assign q_arr[4] = Q4;
  assign q_arr[5] = Q5;
  assign q_arr[6] = Q6;
  assign q_arr[7] = Q7;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [2:0]  sel;
    logic [15:0] d;
    logic        clr;
    logic        busy;
    logic        wack;
    logic [2:0]  qi;
    logic [15:0] q;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] sel, input logic [15:0] d, input logic clr);
    WE  = we;
    S0  = sel[0];
    S1  = sel[1];
    S2  = sel[2];
    D   = d;
    CLR = clr;
  endtask

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_q(input string name, input logic [15:0] e0, input logic [15:0] e1,
                           input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4,
                           input logic [15:0] e5, input logic [15:0] e6, input logic [15:0] e7);
    logic [15:0] e [8];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    e[4] = e4; e[5] = e5; e[6] = e6; e[7] = e7;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_q%0d", name, i), {16'h0000, q_arr[i]}, {16'h0000, e[i]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Table rows: we, sel, d, clr, exp busy, exp wack, checked index, exp Q.
    // The table starts from a freshly reset block.
    tbl[0]  = '{1'b1, 3'd5, 16'hBEEF, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0000};
    tbl[1]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd5, 16'hBEEF};
    tbl[2]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd5, 16'hBEEF};
    tbl[3]  = '{1'b1, 3'd2, 16'h1111, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0000};
    tbl[4]  = '{1'b1, 3'd2, 16'h2222, 1'b0, 1'b1, 1'b1, 3'd2, 16'h1111};
    tbl[5]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd2, 16'h2222};
    tbl[6]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd5, 16'hBEEF};
    tbl[7]  = '{1'b1, 3'd0, 16'hAAAA, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0000};
    tbl[8]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000};
    tbl[9]  = '{1'b1, 3'd7, 16'h1234, 1'b0, 1'b1, 1'b0, 3'd7, 16'h0000};
    tbl[10] = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd7, 16'h0000};
    tbl[11] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd7, 16'h0000};

    RST = 1'b0;
    drive(1'b0, 3'd0, 16'h0000, 1'b0);

    // Async reset with no clock edge (first posedge is at t=5).
    #1 RST = 1'b1;
    #1;
    chk_all_q("reset", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    chk("reset_wack", {31'd0, WACK}, 32'd0);
    chk("reset_busy", {31'd0, BUSY}, 32'd0);
    RST = 1'b0;

    // Single write of 0xBEEF to index 5.
    drive(1'b1, 3'd5, 16'hBEEF, 1'b0);
    tick();
    chk("single_busy1", {31'd0, BUSY}, 32'd1);
    chk("single_wack1", {31'd0, WACK}, 32'd0);
    drive(1'b0, 3'd0, 16'h0000, 1'b0);
    tick();
    chk("single_busy2", {31'd0, BUSY}, 32'd0);
    chk("single_wack2", {31'd0, WACK}, 32'd1);
    chk_all_q("single", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hBEEF, 16'h0, 16'h0);

    // Fresh reset before the table.
    RST = 1'b1;
    #1 RST = 1'b0;
    #1;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].we, tbl[i].sel, tbl[i].d, tbl[i].clr);
      tick();
      chk($sformatf("vec%0d_busy", i), {31'd0, BUSY}, {31'd0, tbl[i].busy});
      chk($sformatf("vec%0d_wack", i), {31'd0, WACK}, {31'd0, tbl[i].wack});
      chk($sformatf("vec%0d_q%0d", i, tbl[i].qi), {16'h0000, q_arr[tbl[i].qi]}, {16'h0000, tbl[i].q});
    end

    // Burst: eight back-to-back writes, then two idle edges.
    for (int n = 0; n < 10; n++) begin
      if (n < 8) begin
        drive(1'b1, n[2:0], 16'h1000 + n[15:0], 1'b0);
      end else begin
        drive(1'b0, 3'd0, 16'h0000, 1'b0);
      end
      tick();
      chk($sformatf("burst%0d_busy", n), {31'd0, BUSY}, (n < 8) ? 32'd1 : 32'd0);
      chk($sformatf("burst%0d_wack", n), {31'd0, WACK}, (n >= 1 && n <= 8) ? 32'd1 : 32'd0);
      if (n >= 1 && n <= 8) begin
        chk($sformatf("burst%0d_q", n), {16'h0000, q_arr[n-1]}, 32'h1000 + n - 1);
      end
    end
    chk_all_q("burst", 16'h1000, 16'h1001, 16'h1002, 16'h1003,
              16'h1004, 16'h1005, 16'h1006, 16'h1007);

    // Abort by CLR: a pending write to index 6 is discarded and all Q clear.
    drive(1'b1, 3'd6, 16'h6666, 1'b0);
    tick();
    chk("clrab_busy1", {31'd0, BUSY}, 32'd1);
    drive(1'b0, 3'd0, 16'h0000, 1'b1);
    tick();
    chk("clrab_busy2", {31'd0, BUSY}, 32'd0);
    chk("clrab_wack2", {31'd0, WACK}, 32'd0);
    chk_all_q("clrab", 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    drive(1'b0, 3'd0, 16'h0000, 1'b0);
    tick();
    chk("clrab_wack3", {31'd0, WACK}, 32'd0);
    chk("clrab_q6", {16'h0000, Q6}, 32'h0000);

    // Put a value in Q3 so the async reset has something to clear.
    drive(1'b1, 3'd3, 16'h5A5A, 1'b0);
    tick();
    drive(1'b0, 3'd0, 16'h0000, 1'b0);
    tick();
    chk("pre_rst_q3", {16'h0000, Q3}, 32'h5A5A);

    // Abort by RST between the capture edge and the commit edge.
    drive(1'b1, 3'd6, 16'h6666, 1'b0);
    tick();
    chk("rstab_busy1", {31'd0, BUSY}, 32'd1);
    drive(1'b0, 3'd0, 16'h0000, 1'b0);
    RST = 1'b1;
    #1;
    chk("rstab_busy_now", {31'd0, BUSY}, 32'd0);
    chk("rstab_q3_now", {16'h0000, Q3}, 32'h0000);
    RST = 1'b0;
    tick();
    chk("rstab_wack2", {31'd0, WACK}, 32'd0);
    chk("rstab_busy2", {31'd0, BUSY}, 32'd0);
    chk("rstab_q6", {16'h0000, Q6}, 32'h0000);

    // The first write after reset release is accepted on the next edge.
    drive(1'b1, 3'd1, 16'h7777, 1'b0);
    tick();
    chk("post_rst_busy", {31'd0, BUSY}, 32'd1);
    drive(1'b0, 3'd0, 16'h0000, 1'b0);
    tick();
    chk("post_rst_wack", {31'd0, WACK}, 32'd1);
    chk_all_q("post_rst", 16'h0, 16'h7777, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
